// File: rtl/lc3_writeback_arbiter_if.sv
// Writeback bus between the LC3 pipeline and the writeback arbiter.
// Master drives requests and read indices; slave returns read data, psr and status.
interface lc3_writeback_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8
);
   localparam int IDX_W = $clog2(NREG);

   logic              enable_writeback;
   logic              ex_valid;
   logic              ex_ready;
   logic [DATA_W-1:0] ex_data;
   logic [IDX_W-1:0]  ex_dr;
   logic              mem_valid;
   logic [DATA_W-1:0] mem_data;
   logic [IDX_W-1:0]  mem_dr;
   logic [IDX_W-1:0]  sr1;
   logic [IDX_W-1:0]  sr2;
   logic [DATA_W-1:0] VSR1;
   logic [DATA_W-1:0] VSR2;
   logic [2:0]        psr;
   logic              wb_busy;

   modport master (
      output enable_writeback, ex_valid, ex_data, ex_dr,
             mem_valid, mem_data, mem_dr, sr1, sr2,
      input  ex_ready, VSR1, VSR2, psr, wb_busy
   );

   modport slave (
      input  enable_writeback, ex_valid, ex_data, ex_dr,
             mem_valid, mem_data, mem_dr, sr1, sr2,
      output ex_ready, VSR1, VSR2, psr, wb_busy
   );
endinterface

// File: rtl/lc3_writeback_arbiter.sv
// LC3 writeback: commits mem > held ex > new ex into the register file, one per cycle.
// Direct commits land on the request edge; colliding ex is held one entry and ex_ready drops.
module lc3_writeback_arbiter #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   lc3_writeback_arbiter_if.slave  wb
);
   localparam int IDX_W = $clog2(NREG);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] hold_data;
   logic [IDX_W-1:0]  hold_dr;
   logic [2:0]        psr_q;

   logic              ex_acc;
   logic              cap;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_dr;
   logic [DATA_W-1:0] wr_dat;
   logic [2:0]        psr_nxt;

   // ex_ready depends on registered state only
   assign wb.ex_ready = (state == IDLE);
   assign wb.wb_busy  = (state == HOLD);
   assign ex_acc      = wb.ex_valid && (state == IDLE);

   always_comb begin
      state_nxt = state;
      cap       = 1'b0;
      wr_en     = 1'b0;
      wr_dr     = wb.ex_dr;
      wr_dat    = wb.ex_data;
      case (state)
         IDLE: begin
            if (wb.enable_writeback) begin
               if (wb.mem_valid) begin
                  wr_en  = 1'b1;
                  wr_dr  = wb.mem_dr;
                  wr_dat = wb.mem_data;
                  if (ex_acc) begin
                     cap       = 1'b1;
                     state_nxt = HOLD;
                  end
               end else if (ex_acc) begin
                  wr_en = 1'b1;
               end
            end else if (ex_acc) begin
               cap       = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (wb.enable_writeback) begin
               wr_en = 1'b1;
               if (wb.mem_valid) begin
                  wr_dr  = wb.mem_dr;
                  wr_dat = wb.mem_data;
               end else begin
                  wr_dr     = hold_dr;
                  wr_dat    = hold_data;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // N/Z/P from the committed word; exactly one bit set
   always_comb begin
      psr_nxt = psr_q;
      if (wr_en) begin
         if (wr_dat[DATA_W-1])  psr_nxt = 3'b100;
         else if (wr_dat == '0) psr_nxt = 3'b010;
         else                   psr_nxt = 3'b001;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         hold_data <= '0;
         hold_dr   <= '0;
         psr_q     <= 3'b010;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         state <= state_nxt;
         psr_q <= psr_nxt;
         if (cap) begin
            hold_data <= wb.ex_data;
            hold_dr   <= wb.ex_dr;
         end
         if (wr_en) regs[wr_dr] <= wr_dat;
      end
   end

   // No bypass: decode stalls on wb_busy instead
   assign wb.VSR1 = regs[wb.sr1];
   assign wb.VSR2 = regs[wb.sr2];
   assign wb.psr  = psr_q;
endmodule

// File: tb/tb_lc3_writeback_arbiter.sv
// Directed vector table plus hand sequences for reset and reset-during-hold.
module tb_lc3_writeback_arbiter;
   logic clk;
   logic rst;

   lc3_writeback_arbiter_if #(.DATA_W(16), .NREG(8)) wb_if_i ();

   lc3_writeback_arbiter #(.DATA_W(16), .NREG(8)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb_if_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        exv;
      logic [15:0] exd;
      logic [2:0]  exdr;
      logic        memv;
      logic [15:0] memd;
      logic [2:0]  memdr;
      logic [2:0]  s1;
      logic [2:0]  s2;
      logic [15:0] e_vsr1;
      logic [15:0] e_vsr2;
      logic [2:0]  e_psr;
      logic        e_busy;
      logic        e_rdy;
   } vec_t;

   vec_t vecs [13];
   int   n_cmp;
   int   n_bad;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic exv, input logic [15:0] exd, input logic [2:0] exdr,
                        input logic memv, input logic [15:0] memd, input logic [2:0] memdr,
                        input logic [2:0] s1, input logic [2:0] s2);
      wb_if_i.enable_writeback = en;
      wb_if_i.ex_valid         = exv;
      wb_if_i.ex_data          = exd;
      wb_if_i.ex_dr            = exdr;
      wb_if_i.mem_valid        = memv;
      wb_if_i.mem_data         = memd;
      wb_if_i.mem_dr           = memdr;
      wb_if_i.sr1              = s1;
      wb_if_i.sr2              = s2;
   endtask

   task automatic idle_inputs();
      drive(1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 16'h0, 3'd0, 3'd0, 3'd0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_psr"},  {13'b0, wb_if_i.psr}, 16'h0002);
      check({tag, "_rdy"},  {15'b0, wb_if_i.ex_ready}, 16'h0001);
      check({tag, "_busy"}, {15'b0, wb_if_i.wb_busy}, 16'h0000);
      for (int r = 0; r < 8; r++) begin
         wb_if_i.sr1 = r[2:0];
         wb_if_i.sr2 = 3'(7 - r);
         #1;
         check($sformatf("%s_vsr1_r%0d", tag, r), wb_if_i.VSR1, 16'h0000);
         check($sformatf("%s_vsr2_r%0d", tag, 7 - r), wb_if_i.VSR2, 16'h0000);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      //          en  exv  exd      exdr memv memd     memdr s1  s2   vsr1     vsr2     psr     busy rdy
      vecs[0]  = '{1, 1, 16'h8001, 3, 0, 16'h0000, 0, 3, 0, 16'h8001, 16'h0000, 3'b100, 0, 1};
      vecs[1]  = '{1, 1, 16'h0007, 5, 1, 16'h0000, 2, 5, 2, 16'h0000, 16'h0000, 3'b010, 1, 0};
      vecs[2]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 5, 3, 16'h0007, 16'h8001, 3'b001, 0, 1};
      vecs[3]  = '{1, 1, 16'h2222, 4, 1, 16'h1111, 4, 4, 0, 16'h1111, 16'h0000, 3'b001, 1, 0};
      vecs[4]  = '{1, 1, 16'h1234, 7, 1, 16'h8000, 6, 4, 6, 16'h1111, 16'h8000, 3'b100, 1, 0};
      vecs[5]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 4, 7, 16'h2222, 16'h0000, 3'b001, 0, 1};
      vecs[6]  = '{0, 1, 16'hFFFF, 1, 0, 16'h0000, 0, 1, 4, 16'h0000, 16'h2222, 3'b001, 1, 0};
      vecs[7]  = '{0, 1, 16'hFFFF, 1, 0, 16'h0000, 0, 1, 4, 16'h0000, 16'h2222, 3'b001, 1, 0};
      vecs[8]  = '{0, 1, 16'hFFFF, 1, 0, 16'h0000, 0, 1, 4, 16'h0000, 16'h2222, 3'b001, 1, 0};
      vecs[9]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 5, 16'hFFFF, 16'h0007, 3'b100, 0, 1};
      vecs[10] = '{1, 0, 16'h0000, 0, 1, 16'h0005, 0, 0, 1, 16'h0005, 16'hFFFF, 3'b001, 0, 1};
      vecs[11] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 6, 16'h0005, 16'h8000, 3'b001, 0, 1};
      vecs[12] = '{1, 1, 16'h0000, 2, 0, 16'h0000, 0, 2, 1, 16'h0000, 16'hFFFF, 3'b010, 0, 1};

      idle_inputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("rst0");
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].en, vecs[i].exv, vecs[i].exd, vecs[i].exdr,
               vecs[i].memv, vecs[i].memd, vecs[i].memdr, vecs[i].s1, vecs[i].s2);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_vsr1", i), wb_if_i.VSR1, vecs[i].e_vsr1);
         check($sformatf("v%0d_vsr2", i), wb_if_i.VSR2, vecs[i].e_vsr2);
         check($sformatf("v%0d_psr", i),  {13'b0, wb_if_i.psr}, {13'b0, vecs[i].e_psr});
         check($sformatf("v%0d_busy", i), {15'b0, wb_if_i.wb_busy}, {15'b0, vecs[i].e_busy});
         check($sformatf("v%0d_rdy", i),  {15'b0, wb_if_i.ex_ready}, {15'b0, vecs[i].e_rdy});
         @(negedge clk);
      end

      // asynchronous reset mid-run, away from any clock edge
      idle_inputs();
      #2;
      rst = 1'b0;
      #1;
      check_reset_state("rst_mid");
      @(negedge clk);
      rst = 1'b1;

      // collision on the first edge after reset, then reset while holding
      drive(1'b1, 1'b1, 16'h5555, 3'd3, 1'b1, 16'h00AA, 3'd2, 3'd2, 3'd3);
      @(posedge clk);
      #1;
      check("hold_r2",   wb_if_i.VSR1, 16'h00AA);
      check("hold_r3",   wb_if_i.VSR2, 16'h0000);
      check("hold_busy", {15'b0, wb_if_i.wb_busy}, 16'h0001);
      check("hold_rdy",  {15'b0, wb_if_i.ex_ready}, 16'h0000);
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      #1;
      check("hrst_busy", {15'b0, wb_if_i.wb_busy}, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      wb_if_i.enable_writeback = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("hrst_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lc3_writeback_arbiter.md
# lc3_writeback_arbiter

Sequencing controller for the LC3 writeback stage: arbitrates register-file write requests from the execute path (ALU/PC results) and the memory path (load data), owns the 8x16 general-purpose register file, and generates the condition codes. It drives the VSR1/VSR2/psr signals seen on the writeback_out bus. A one-entry hold buffer absorbs execute/memory write collisions so that no write is lost and program order is preserved.

## Interface
- DATA_W, 16, register and data width
- NREG, 8, number of general-purpose registers (index width log2(NREG) = 3)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- enable_writeback  in  1  global commit enable from controller
- ex_valid  in  1  execute-path write request
- ex_ready  out  1  execute request accepted this cycle when ex_valid & ex_ready
- ex_data  in  16  execute result (aluout or pcout, preselected upstream)
- ex_dr  in  3  execute destination register
- mem_valid  in  1  memory-path (load) write request, no back-pressure
- mem_data  in  16  load data
- mem_dr  in  3  load destination register
- sr1, sr2  in  3  read register indices
- VSR1, VSR2  out  16  register-file read data for sr1/sr2
- psr  out  3  condition codes {N,Z,P}
- wb_busy  out  1  hold buffer occupied

## Operation
- States: IDLE (hold buffer empty), HOLD (hold buffer holds one execute write: data, dr).
- ex_ready = (state == IDLE); registered-state decode only, no combinational path from any input.
- Commit priority when enable_writeback=1: mem > hold buffer > new ex. At most one register write per cycle.
- IDLE, en=1, mem_valid, ex accepted: commit mem; capture ex into hold buffer -> HOLD.
- IDLE, en=1, ex accepted only: commit ex directly; stay IDLE.
- IDLE, en=1, mem_valid only: commit mem.
- HOLD, en=1, mem_valid: commit mem; stay HOLD.
- HOLD, en=1, no mem_valid: commit hold buffer -> IDLE.
- en=0: no commits. An ex accepted in IDLE is captured -> HOLD. mem_valid is ignored (upstream must not assert it). HOLD persists.
- Same dr on mem and captured ex in one cycle: mem commits first, held ex commits later, so the ex value is final (program order: ex is the younger instruction).
- PSR updated only on commit, from the committed data: N=data[15]; Z=(data==0); P=!N&!Z. Exactly one bit is set.
- VSR1/VSR2: combinational reads of register file at sr1/sr2. No bypass of same-cycle commit or of hold buffer; decode stalls on wb_busy.
- wb_busy = (state == HOLD).

## Timing
- Reset (rst=0, async): all registers 0, psr=3'b010, state IDLE, hold buffer invalid, ex_ready=1, wb_busy=0, VSR1=VSR2=0.
- Reset mid-HOLD: held write is discarded, not committed.
- Reset deassertion is synchronized externally. The first commit can occur on the first rising edge with rst=1.
- Direct commit latency: the register and psr update on the edge ending the request cycle. Visible on VSR/psr in the next cycle.
- Collision latency for ex: 2 edges (hold, then commit), longer while mem_valid persists or en=0.
- ex_ready low for every cycle in HOLD. ex_valid & !ex_ready has no effect; requester holds data stable.
- Continuous mem_valid with en=1 starves the hold buffer indefinitely. This is by design; the memory path is bounded by the pipeline.

## Test plan
- Reset: assert rst=0 mid-run -> all VSR reads 0, psr=3'b010, ex_ready=1, wb_busy=0.
- Direct ex write: en=1, ex_valid, ex_dr=3, ex_data=16'h8001 -> next cycle sr1=3 gives VSR1=16'h8001, psr=3'b100.
- Collision: en=1, mem_valid mem_dr=2 mem_data=0, ex_valid ex_dr=5 ex_data=16'h0007 -> cycle+1: R2=0, psr=3'b010, wb_busy=1, ex_ready=0. Cycle+2: R5=7, psr=3'b001, wb_busy=0.
- Same-register collision: mem_dr=ex_dr=4, mem_data=16'h1111, ex_data=16'h2222 -> R4 ends at 16'h2222.
- Enable low: en=0, ex_valid ex_dr=1 ex_data=16'hFFFF for 3 cycles -> no register change, wb_busy=1 after first edge. Raise en -> R1=16'hFFFF, psr=3'b100 one edge later.
- Reset during HOLD: create collision, assert rst=0 in HOLD -> held data never appears in any register, state IDLE.
